// File: rtl/aexm_memseq.sv
// Memory-operation sequencer: holds the pipeline while data-side cache channels
// are enabled one after another, lowest channel first, with an optional busy timeout.
module aexm_memseq #(
  parameter int NCH = 2,
  parameter int CW  = 1,
  parameter int TOW = 8
) (
  input  logic           sys_clk_i,
  input  logic           sys_rst_i,
  input  logic [NCH-1:0] cache_busy,
  input  logic [NCH-1:0] memop_req,
  input  logic           dSKIP,
  input  logic           fSTALL,
  input  logic [TOW-1:0] timeout_lim,
  output logic           cpu_enable,
  output logic [NCH-1:0] cache_enable,
  output logic           cpu_mode_memop,
  output logic [CW-1:0]  memop_ch,
  output logic           timeout_err
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM = 2'd1, ERR = 2'd2} state_t;

  state_t         stateReg, stateNext;
  logic [NCH-1:0] pendReg, pendNext;
  logic [TOW-1:0] tcntReg, tcntNext;
  logic [CW-1:0]  chReg, chNext;
  logic           errReg, errNext;

  logic [NCH-1:0] vreq;
  logic           runEnable;
  logic           issue;
  logic           busyCur;
  logic           timeoutHit;
  logic [TOW:0]   tcntInc;
  logic [CW-1:0]  issueIdx;
  logic [CW-1:0]  pendIdx;
  logic           unusedReqBit;

  // Index of the lowest set bit at or above position 1; bit 0 (instruction side) never queues.
  function automatic logic [CW-1:0] lowIdx(input logic [NCH-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 1; i--) begin
      if (v[i]) r = CW'(i);
    end
    return r;
  endfunction

  assign unusedReqBit = memop_req[0];
  assign vreq       = {memop_req[NCH-1:1] & {(NCH-1){~dSKIP}}, 1'b0};
  assign runEnable  = ~|cache_busy;
  assign issue      = (stateReg == RUN) & runEnable & (|vreq);
  assign busyCur    = cache_busy[chReg];
  assign tcntInc    = {1'b0, tcntReg} + (TOW+1)'(1);
  // Compare the unsaturated increment so a saturated counter never matches again.
  assign timeoutHit = (timeout_lim != '0) && (tcntInc == {1'b0, timeout_lim});
  assign issueIdx   = lowIdx(vreq);
  assign pendIdx    = lowIdx(pendReg);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      stateReg <= RUN;
      pendReg  <= '0;
      tcntReg  <= '0;
      chReg    <= '0;
      errReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      pendReg  <= pendNext;
      tcntReg  <= tcntNext;
      chReg    <= chNext;
      errReg   <= errNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    pendNext  = pendReg;
    tcntNext  = tcntReg;
    chNext    = chReg;
    errNext   = errReg;
    case (stateReg)
      RUN: begin
        if (issue) begin
          stateNext = MEM;
          pendNext  = vreq & (vreq - NCH'(1));
          chNext    = issueIdx;
          tcntNext  = '0;
        end
      end
      MEM: begin
        if (busyCur) begin
          tcntNext = (tcntReg == '1) ? tcntReg : tcntInc[TOW-1:0];
          if (timeoutHit) begin
            stateNext = ERR;
            errNext   = 1'b1;
          end
        end else if (pendReg != '0) begin
          pendNext = pendReg & (pendReg - NCH'(1));
          chNext   = pendIdx;
          tcntNext = '0;
        end else begin
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = ERR;
        errNext   = 1'b1;
      end
    endcase
  end

  always_comb begin
    cpu_enable     = 1'b0;
    cache_enable   = '0;
    cpu_mode_memop = 1'b0;
    memop_ch       = '0;
    timeout_err    = 1'b0;
    if (!sys_rst_i) begin
      memop_ch    = chReg;
      timeout_err = errReg;
      case (stateReg)
        RUN: begin
          cpu_enable      = runEnable;
          cache_enable[0] = runEnable & ~fSTALL;
          if (issue) cache_enable = cache_enable | (vreq & (~vreq + NCH'(1)));
        end
        MEM: begin
          cpu_mode_memop = 1'b1;
          if (!busyCur && pendReg != '0) cache_enable = pendReg & (~pendReg + NCH'(1));
        end
        default: timeout_err = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_aexm_memseq.sv
// Randomized bench for aexm_memseq with a queue-based reference model and
// hand-computed checkpoints for the documented scenarios.
module tb_aexm_memseq;
  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int TOW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] req;
  logic           skip;
  logic           stall;
  logic [TOW-1:0] lim;
  logic           cpuEn;
  logic [NCH-1:0] ce;
  logic           modeMem;
  logic [CW-1:0]  ch;
  logic           err;

  always #5 clk = ~clk;

  aexm_memseq #(.NCH(NCH), .CW(CW), .TOW(TOW)) dut (
    .sys_clk_i      (clk),
    .sys_rst_i      (rst),
    .cache_busy     (busy),
    .memop_req      (req),
    .dSKIP          (skip),
    .fSTALL         (stall),
    .timeout_lim    (lim),
    .cpu_enable     (cpuEn),
    .cache_enable   (ce),
    .cpu_mode_memop (modeMem),
    .memop_ch       (ch),
    .timeout_err    (err)
  );

  int checks = 0;
  int failures = 0;

  // Model: mode 0=running, 1=servicing, 2=error; q lists channels still to be enabled.
  int mMode = 0;
  int q[$];
  int mCh = 0;
  int mCnt = 0;
  int mErr = 0;

  logic [NCH-1:0] lastCe;
  logic           lastCpuEn, lastMode, lastErr;
  logic [CW-1:0]  lastCh;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endfunction

  task automatic step(input logic r, input logic [NCH-1:0] b, input logic [NCH-1:0] rq,
                      input logic s, input logic st, input int l);
    int eEn, eCe, eMode, eCh, eErr, reqs, nc;
    @(posedge clk);
    #1;
    rst = r; busy = b; req = rq; skip = s; stall = st; lim = l[TOW-1:0];
    @(negedge clk);
    eEn = 0; eCe = 0; eMode = 0; eCh = 0; eErr = 0;
    if (r) begin
      mMode = 0; q.delete(); mCh = 0; mCnt = 0; mErr = 0;
    end else begin
      eCh = mCh; eErr = mErr;
      case (mMode)
        0: begin
          eEn = (b == 0) ? 1 : 0;
          if (eEn == 1 && !st) eCe = 1;
          reqs = s ? 0 : (int'(rq) & ~1);
          if (eEn == 1 && reqs != 0) begin
            for (int i = 1; i < NCH; i++) if (reqs[i]) q.push_back(i);
            $display("issue t=%0t channels=%b", $time, reqs[NCH-1:0]);
            mCh = q.pop_front();
            eCe = eCe | (1 << mCh);
            mCnt = 0;
            mMode = 1;
          end
        end
        1: begin
          eMode = 1;
          if (b[mCh]) begin
            nc = mCnt + 1;
            if (l != 0 && nc == l) begin mMode = 2; mErr = 1; end
            mCnt = (nc > 255) ? 255 : nc;
          end else if (q.size() > 0) begin
            mCh = q.pop_front();
            eCe = 1 << mCh;
            mCnt = 0;
          end else begin
            mMode = 0;
          end
        end
        default: eErr = 1;
      endcase
    end
    chk("cpu_enable", 32'(cpuEn), eEn);
    chk("cache_enable", 32'(ce), eCe);
    chk("cpu_mode_memop", 32'(modeMem), eMode);
    chk("memop_ch", 32'(ch), eCh);
    chk("timeout_err", 32'(err), eErr);
    lastCe = ce; lastCpuEn = cpuEn; lastMode = modeMem; lastErr = err; lastCh = ch;
  endtask

  initial begin
    logic [NCH-1:0] rb, rr;
    rst = 1'b1; busy = '0; req = '0; skip = 1'b0; stall = 1'b0; lim = '0;

    // Reset dominates every other input.
    step(1, 4'b1111, 4'b1110, 0, 0, 3);
    chk("lit_rst_ce", 32'(lastCe), 0);
    chk("lit_rst_cpu", 32'(lastCpuEn), 0);
    step(1, 4'b0000, 4'b1110, 0, 0, 0);

    // Single access, no busy: stall of exactly one cycle.
    step(0, 4'b0000, 4'b0010, 0, 0, 0);
    chk("lit_single_ce", 32'(lastCe), 32'h3);
    step(0, 4'b0000, 4'b0000, 0, 0, 0);
    chk("lit_single_mem_cpu", 32'(lastCpuEn), 0);
    chk("lit_single_mem_mode", 32'(lastMode), 1);
    step(0, 4'b0000, 4'b0000, 0, 0, 0);
    chk("lit_single_run_cpu", 32'(lastCpuEn), 1);

    // Three channels back to back.
    step(0, 4'b0000, 4'b1110, 0, 0, 0);
    chk("lit_multi_ce0", 32'(lastCe), 32'h3);
    step(0, 4'b0000, 4'b0000, 0, 0, 0);
    chk("lit_multi_ce1", 32'(lastCe), 32'h4);
    chk("lit_multi_ch1", 32'(lastCh), 1);
    step(0, 4'b0000, 4'b0000, 0, 0, 0);
    chk("lit_multi_ce2", 32'(lastCe), 32'h8);
    chk("lit_multi_ch2", 32'(lastCh), 2);
    step(0, 4'b0000, 4'b0000, 0, 0, 0);
    chk("lit_multi_ch3", 32'(lastCh), 3);
    step(0, 4'b0000, 4'b0000, 0, 0, 0);
    chk("lit_multi_run", 32'(lastMode), 0);

    // Five busy cycles, timeout disabled.
    step(0, 4'b0000, 4'b0010, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 4'b0010, 4'b0000, 0, 0, 0);
    chk("lit_busy_mode", 32'(lastMode), 1);
    step(0, 4'b0000, 4'b0000, 0, 0, 0);
    step(0, 4'b0000, 4'b0000, 0, 0, 0);
    chk("lit_busy_run_cpu", 32'(lastCpuEn), 1);
    chk("lit_busy_noerr", 32'(lastErr), 0);

    // Timeout after three busy cycles, then reset recovery.
    step(0, 4'b0000, 4'b0010, 0, 0, 3);
    for (int i = 0; i < 3; i++) step(0, 4'b0010, 4'b0000, 0, 0, 3);
    step(0, 4'b0010, 4'b0000, 0, 0, 3);
    chk("lit_err_flag", 32'(lastErr), 1);
    chk("lit_err_cpu", 32'(lastCpuEn), 0);
    step(0, 4'b0000, 4'b0010, 0, 0, 3);
    chk("lit_err_ce", 32'(lastCe), 0);
    step(1, 4'b0000, 4'b0000, 0, 0, 3);
    step(0, 4'b0000, 4'b0000, 0, 0, 3);
    chk("lit_err_cleared", 32'(lastErr), 0);
    chk("lit_err_run_cpu", 32'(lastCpuEn), 1);

    // Skipped request, then instruction cache busy.
    step(0, 4'b0000, 4'b0010, 1, 0, 0);
    chk("lit_skip_ce", 32'(lastCe), 32'h1);
    step(0, 4'b0001, 4'b0010, 0, 0, 0);
    chk("lit_ibusy_cpu", 32'(lastCpuEn), 0);
    chk("lit_ibusy_ce", 32'(lastCe), 0);

    // Fetch stall during issue.
    step(0, 4'b0000, 4'b0100, 0, 1, 0);
    chk("lit_stall_ce", 32'(lastCe), 32'h4);
    step(0, 4'b0000, 4'b0000, 0, 0, 0);

    // Reset while channels are still pending.
    step(0, 4'b0000, 4'b1110, 0, 0, 0);
    step(1, 4'b0000, 4'b0000, 0, 0, 0);
    chk("lit_abandon_ce", 32'(lastCe), 0);
    step(0, 4'b0000, 4'b0000, 0, 0, 0);
    chk("lit_abandon_ce_run", 32'(lastCe), 32'h1);
    chk("lit_abandon_mode", 32'(lastMode), 0);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < NCH; k++) begin
        rb[k] = ($urandom_range(0, 3) == 0);
        rr[k] = $urandom_range(0, 1);
      end
      step($urandom_range(0, 49) == 0, rb, rr, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,
           ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
